pslip_grant_arbiter: RTL and testbench



---
 rtl/pslip_grant_arbiter.sv | 114 +++++++++++
 tb/tb_pslip_grant_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pslip_grant_arbiter.sv
// pSLIP output-side grant arbiter: latches the filtered request vector, issues a round-robin one-hot grant,
// then waits for accept. Latency 2 cycles from req_valid to gnt_valid; no queueing, req_valid is dropped while busy.
module pslip_grant_arbiter #(
  parameter int N       = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 req_valid,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  input  logic                 accept_valid,
  input  logic                 accept,
  input  logic                 first_iter,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARB, WAIT_ACC} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   req_q;
  logic [IW-1:0]  ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_found;
  logic           cnt_done;

  assign cnt_done = (cnt == CW'(TIMEOUT - 1));

  // Scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; wrap by explicit compare so non-power-of-2 N works.
  always_comb begin
    int j;
    j         = 0;
    arb_gnt   = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!arb_found && req_q[j]) begin
        arb_found  = 1'b1;
        arb_gnt[j] = 1'b1;
        arb_idx    = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = ARB;
      ARB:      state_nxt = arb_found ? WAIT_ACC : IDLE;
      WAIT_ACC: if (accept_valid || cnt_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Pointer advances only on a first-iteration accept, which keeps outputs from synchronising.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) req_q <= req;
        end
        ARB: begin
          gnt       <= arb_gnt;
          gnt_idx   <= arb_idx;
          gnt_valid <= 1'b1;
          cnt       <= '0;
        end
        WAIT_ACC: begin
          if (accept_valid) begin
            if (accept && first_iter)
              ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            cnt <= '0;
          end else if (cnt_done) begin
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pslip_grant_arbiter.sv
// Bench for pslip_grant_arbiter: directed requests push expected grants/timeouts into queues,
// and negedge monitors pop and compare whenever the DUT pulses gnt_valid or timeout.
module tb_pslip_grant_arbiter;

  localparam int N  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         req_valid;
  logic [N-1:0] gnt;
  logic [3:0]   gnt_idx;
  logic         gnt_valid;
  logic         accept_valid;
  logic         accept;
  logic         first_iter;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [N-1:0] exp_gnt_q[$];
  logic [3:0]   exp_idx_q[$];
  int           exp_cyc_q[$];
  int           exp_to_q[$];

  logic [N-1:0] m_gnt;
  logic [3:0]   m_idx;
  int           m_cyc;

  pslip_grant_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_valid    (req_valid),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .accept_valid (accept_valid),
    .accept       (accept),
    .first_iter   (first_iter),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request pulse in cycle t; returns in cycle t+2 with the grant outstanding.
  task automatic issue(input logic [N-1:0] r, input logic [N-1:0] eg, input logic [3:0] ei);
    req       = r;
    req_valid = 1'b1;
    exp_gnt_q.push_back(eg);
    exp_idx_q.push_back(ei);
    exp_cyc_q.push_back(cyc + 2);
    step();
    req_valid = 1'b0;
    req       = '0;
    step();
  endtask

  task automatic acc(input logic a, input logic f);
    accept_valid = 1'b1;
    accept       = a;
    first_iter   = f;
    step();
    accept_valid = 1'b0;
    accept       = 1'b0;
    first_iter   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (gnt_valid === 1'b1) begin
      checks++;
      if (exp_gnt_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got gnt=%h idx=%0d at cycle %0d, required no grant", gnt, gnt_idx, cyc);
      end else begin
        m_gnt = exp_gnt_q.pop_front();
        m_idx = exp_idx_q.pop_front();
        m_cyc = exp_cyc_q.pop_front();
        if (gnt !== m_gnt || gnt_idx !== m_idx || cyc != m_cyc) begin
          errors++;
          $display("FAIL grant: got gnt=%h idx=%0d cycle=%0d required gnt=%h idx=%0d cycle=%0d",
                   gnt, gnt_idx, cyc, m_gnt, m_idx, m_cyc);
        end
      end
    end
    if (timeout === 1'b1) begin
      checks++;
      if (exp_to_q.size() == 0) begin
        errors++;
        $display("FAIL timeout_unexpected: got timeout at cycle %0d, required none", cyc);
      end else begin
        m_cyc = exp_to_q.pop_front();
        if (cyc != m_cyc) begin
          errors++;
          $display("FAIL timeout: got cycle %0d required cycle %0d", cyc, m_cyc);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    req          = '0;
    req_valid    = 1'b0;
    accept_valid = 1'b0;
    accept       = 1'b0;
    first_iter   = 1'b0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step();

    // Round-robin advance on first-iteration accepts, with wrap.
    issue(16'h0011, 16'h0001, 4'd0);
    chk("busy_wait_acc", busy, 1);
    acc(1'b1, 1'b1);
    chk("gnt_hold", gnt, 16'h0001);
    issue(16'h0011, 16'h0010, 4'd4);  acc(1'b1, 1'b1);
    issue(16'h0011, 16'h0001, 4'd0);  acc(1'b1, 1'b1);

    // Pointer wrap from the top index.
    issue(16'h8000, 16'h8000, 4'd15); acc(1'b1, 1'b1);
    issue(16'h8001, 16'h0001, 4'd0);  acc(1'b0, 1'b1);
    issue(16'h4000, 16'h4000, 4'd14); acc(1'b1, 1'b1);
    issue(16'h8001, 16'h8000, 4'd15); acc(1'b1, 1'b1);
    issue(16'h8001, 16'h0001, 4'd0);  acc(1'b0, 1'b1);

    // Reject and non-first-iteration accept leave the pointer alone.
    issue(16'h0011, 16'h0001, 4'd0);  acc(1'b0, 1'b1);
    issue(16'h0011, 16'h0001, 4'd0);  acc(1'b1, 1'b0);
    issue(16'h0011, 16'h0001, 4'd0);  acc(1'b1, 1'b1);

    // Empty request: grant pulse with zero vector, no wait.
    issue(16'h0000, 16'h0000, 4'd0);
    step();
    chk("null_busy_t3", busy, 0);
    chk("null_gnt_hold", gnt, 0);
    issue(16'h0011, 16'h0010, 4'd4);  acc(1'b0, 1'b1);

    // Timeout with no accept: pulse at t+10, pointer unchanged.
    exp_to_q.push_back(cyc + 10);
    issue(16'h0004, 16'h0004, 4'd2);
    repeat (7) step();
    chk("to_busy_t9", busy, 1);
    step();
    chk("to_busy_t10", busy, 0);
    issue(16'h0011, 16'h0010, 4'd4);  acc(1'b0, 1'b1);

    // Accept on the terminal count beats the timeout.
    issue(16'h0004, 16'h0004, 4'd2);
    repeat (7) step();
    acc(1'b1, 1'b1);
    chk("late_acc_busy", busy, 0);
    issue(16'h000C, 16'h0008, 4'd3);  acc(1'b0, 1'b1);

    // Reset mid-wait after ptr=5, with an ignored req_valid while busy.
    issue(16'h0011, 16'h0010, 4'd4);  acc(1'b1, 1'b1);
    issue(16'h0040, 16'h0040, 4'd6);
    req       = 16'h0001;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req       = '0;
    reset     = 1'b0;
    step();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_idx", gnt_idx, 0);
    chk("mid_rst_gnt_valid", gnt_valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b1;
    step();
    issue(16'h8001, 16'h0001, 4'd0);  acc(1'b1, 1'b1);

    repeat (12) step();
    chk("grants_outstanding", exp_gnt_q.size(), 0);
    chk("timeouts_outstanding", exp_to_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
